// File: rtl/knn_pkg.sv
// ---------------------------------------------------------------------------
// knn_pkg
// Shared definitions for the KNN inference controller and its datapath.
//   - KNN_DEFAULT_W / KNN_DEFAULT_TYPE_W : default query and label widths,
//     shared with the distance unit, sorter and voter.
//   - knn_state_e : 3-bit controller state encoding.
//   - is_phase()  : true for the states guarded by the phase watchdog.
// ---------------------------------------------------------------------------
package knn_pkg;

  localparam int KNN_DEFAULT_W      = 8;
  localparam int KNN_DEFAULT_TYPE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIST   = 3'd1,
    ST_SORT   = 3'd2,
    ST_INFER  = 3'd3,
    ST_RESULT = 3'd4,
    ST_ERROR  = 3'd5
  } knn_state_e;

  // The three datapath phases that wait on a completion pulse.
  function automatic logic is_phase(input knn_state_e s);
    return (s == ST_DIST) || (s == ST_SORT) || (s == ST_INFER);
  endfunction

endpackage

// File: rtl/knn_phase_watchdog.sv
// ---------------------------------------------------------------------------
// knn_phase_watchdog
// Cycle counter that bounds how long one datapath phase may take.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the count at zero (asserted on the edge entering a phase)
//   enable   : count this cycle (high while inside a phase)
//   expired  : count has reached TIMEOUT-1 while enabled
// The count saturates at TIMEOUT-1 so it can never wrap back to a
// non-expired value if the owner lingers.
// ---------------------------------------------------------------------------
module knn_phase_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: the reset is synchronous, so it sits inside the clocked branch and
  // the sensitivity list holds only the clock edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/knn_controller.sv
// ---------------------------------------------------------------------------
// knn_controller
// Sequences one KNN query through distance, sort and vote phases.
//   Parameters : N (training samples), W (query width), K (neighbours),
//                TYPE_W (label width), TIMEOUT (per-phase cycle limit, >= 2)
//   clk, rst   : clock, synchronous active-high reset
//   query_*    : query request handshake (ready only in IDLE)
//   dist_*     : start pulse, latched query and completion to distance unit
//   sort_start / valid_sort        : sorter start pulse and completion
//   infer_start / inference_done / inferred_type : voter start, done, label
//   result_*   : result handshake; value held until accepted
//   busy       : not IDLE;  error : in ERROR, cleared only by err_clr
//   query_count: completed queries, wraps at 2^16
// Start pulses are registered; result_valid, error, busy and query_ready are
// pure state decodes, so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module knn_controller
  import knn_pkg::*;
#(
  parameter int N       = 16,
  parameter int W       = KNN_DEFAULT_W,
  parameter int K       = 3,
  parameter int TYPE_W  = KNN_DEFAULT_TYPE_W,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              query_valid,
  input  logic [W-1:0]      query_data,
  output logic              query_ready,

  output logic              dist_start,
  output logic [W-1:0]      dist_query,
  input  logic              dist_done,

  output logic              sort_start,
  input  logic              valid_sort,

  output logic              infer_start,
  input  logic              inference_done,
  input  logic [TYPE_W-1:0] inferred_type,

  output logic              result_valid,
  output logic [TYPE_W-1:0] result_type,
  input  logic              result_ready,

  output logic              busy,
  output logic              error,
  input  logic              err_clr,
  output logic [15:0]       query_count
);

  // Elaboration-time sanity checks on the configuration.
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("knn_controller: TIMEOUT must be at least 2");
  end
  if ((K < 1) || (K > N)) begin : g_bad_k
    $error("knn_controller: K must lie in 1..N");
  end

  knn_state_e state, state_next;

  logic dist_start_next;
  logic sort_start_next;
  logic infer_start_next;
  logic query_fire;
  logic result_fire;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  // -------------------------------------------------------------------------
  // Next-state and next-pulse logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written here is given a default first; a path that
  // left one unassigned would infer a latch.
  always_comb begin
    state_next       = state;
    query_fire       = 1'b0;
    result_fire      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (query_valid) begin
          query_fire = 1'b1;
          state_next = ST_DIST;
        end
      end
      // In each phase the completion pulse is tested before the watchdog so
      // a done arriving on the expiry cycle still completes normally.
      ST_DIST: begin
        if (dist_done)       state_next = ST_SORT;
        else if (wd_expired) state_next = ST_ERROR;
      end
      ST_SORT: begin
        if (valid_sort)      state_next = ST_INFER;
        else if (wd_expired) state_next = ST_ERROR;
      end
      ST_INFER: begin
        if (inference_done)  state_next = ST_RESULT;
        else if (wd_expired) state_next = ST_ERROR;
      end
      ST_RESULT: begin
        if (result_ready) begin
          result_fire = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (err_clr) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // A start pulse is due in the first cycle of its phase, i.e. on the edge
    // that moves the state into that phase.
    dist_start_next  = (state_next == ST_DIST)  && (state != ST_DIST);
    sort_start_next  = (state_next == ST_SORT)  && (state != ST_SORT);
    infer_start_next = (state_next == ST_INFER) && (state != ST_INFER);
  end

  assign wd_clear  = is_phase(state_next) && (state_next != state);
  assign wd_enable = is_phase(state);

  knn_phase_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      dist_start  <= 1'b0;
      sort_start  <= 1'b0;
      infer_start <= 1'b0;
      dist_query  <= '0;
      result_type <= '0;
      query_count <= '0;
    end else begin
      state       <= state_next;
      dist_start  <= dist_start_next;
      sort_start  <= sort_start_next;
      infer_start <= infer_start_next;

      if (query_fire) begin
        dist_query <= query_data;
      end
      // Captured only on the voter's own completion so the label stays
      // stable through the whole RESULT handshake.
      if ((state == ST_INFER) && inference_done) begin
        result_type <= inferred_type;
      end
      if (result_fire) begin
        query_count <= query_count + 16'd1;
      end
    end
  end

  assign query_ready  = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign result_valid = (state == ST_RESULT);
  assign error        = (state == ST_ERROR);

endmodule
